// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC width, exception-vector bit positions,
// and the types used by the front-end redirect sequencer.
package pipeline_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int FETCH_ERR_BIT  = 0;
    localparam int DECODE_ERR_BIT = 1;
    localparam int CNT_WIDTH      = 32;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_MISPRED = 2'd1,
        CAUSE_DEC     = 2'd2,
        CAUSE_FETCH   = 2'd3
    } redirect_cause_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_e;

    // A fetch fault only poisons IF; everything else also squashes ID.
    function automatic logic cause_flushes_id(input redirect_cause_e cause);
        logic res;
        case (cause)
            CAUSE_MISPRED: res = 1'b1;
            CAUSE_DEC:     res = 1'b1;
            CAUSE_FETCH:   res = 1'b0;
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/redirect_ctrl_sat_counter.sv
// sat_counter: registered up-counter that sticks at all-ones.
module sat_counter
    import pipeline_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count increment pulses, holding at the maximum value once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: picks the oldest flush source, holds IF/ID flushed while an
// outstanding fetch drains, then offers one redirect PC on valid/ready.
// Optional feature macro: REDIRECT_CTRL_PERF_EN enables the perf counters.
module redirect_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = pipeline_pkg::DATA_WIDTH,
    parameter int FETCH_ERR_BIT  = pipeline_pkg::FETCH_ERR_BIT,
    parameter int DECODE_ERR_BIT = pipeline_pkg::DECODE_ERR_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pcp,
    input  logic [DATA_WIDTH-1:0] ex_pcn,
    input  logic [7:0]            exception,
    input  logic [DATA_WIDTH-1:0] trap_vec,
    input  logic                  if_busy,
    input  logic                  redirect_ready,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [1:0]            redirect_cause,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  stall_front,
    output logic [31:0]           mispred_cnt,
    output logic [31:0]           trap_cnt
);

    redirect_state_e       r_state, w_state_nxt;
    redirect_cause_e       r_cause, w_cause_nxt, w_req_cause;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt, w_req_pc;
    logic [DATA_WIDTH-1:0] r_pend_pc, w_pend_pc_nxt, w_slot_pc;
    logic                  r_pend_vld, w_pend_vld_nxt;
    logic                  r_flush_if, w_flush_if_nxt;
    logic                  r_flush_id, w_flush_id_nxt;
    logic                  r_stall, w_stall_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  w_mispred, w_dec, w_fetch, w_handshake;
    logic                  w_unused_exc;

    assign w_mispred    = enable & ex_valid & (ex_pcp != ex_pcn);
    assign w_dec        = enable & exception[DECODE_ERR_BIT];
    assign w_fetch      = enable & exception[FETCH_ERR_BIT];
    assign w_handshake  = r_valid & redirect_ready;
    assign w_unused_exc = ^exception;
    // A mispredict arriving on the handshake cycle is the newest slot content.
    assign w_slot_pc    = w_mispred ? ex_pcn : r_pend_pc;

    // Oldest-first selection among this cycle's flush sources.
    always_comb begin
        w_req_cause = CAUSE_NONE;
        w_req_pc    = '0;
        if (w_mispred) begin
            w_req_cause = CAUSE_MISPRED;
            w_req_pc    = ex_pcn;
        end else if (w_dec) begin
            w_req_cause = CAUSE_DEC;
            w_req_pc    = trap_vec;
        end else if (w_fetch) begin
            w_req_cause = CAUSE_FETCH;
            w_req_pc    = trap_vec;
        end else begin
            w_req_cause = CAUSE_NONE;
            w_req_pc    = '0;
        end
    end

    // Next-state and next-output logic for the IDLE/DRAIN/REDIRECT sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_cause_nxt    = r_cause;
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_pc_nxt  = r_pend_pc;
        w_flush_if_nxt = r_flush_if;
        w_flush_id_nxt = r_flush_id;
        w_stall_nxt    = r_stall;
        w_valid_nxt    = r_valid;
        case (r_state)
            IDLE: begin
                w_pend_vld_nxt = 1'b0;
                if (w_req_cause != CAUSE_NONE) begin
                    w_pc_nxt       = w_req_pc;
                    w_cause_nxt    = w_req_cause;
                    w_flush_if_nxt = 1'b1;
                    w_flush_id_nxt = cause_flushes_id(w_req_cause);
                    w_stall_nxt    = 1'b1;
                    if (if_busy) begin
                        w_state_nxt = DRAIN;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = REDIRECT;
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt    = IDLE;
                    w_pc_nxt       = '0;
                    w_cause_nxt    = CAUSE_NONE;
                    w_flush_if_nxt = 1'b0;
                    w_flush_id_nxt = 1'b0;
                    w_stall_nxt    = 1'b0;
                    w_valid_nxt    = 1'b0;
                end
            end
            DRAIN: begin
                // Exceptions here belong to already-squashed instructions.
                if (w_mispred) begin
                    w_pc_nxt       = ex_pcn;
                    w_cause_nxt    = CAUSE_MISPRED;
                    w_flush_id_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (!if_busy) begin
                    w_state_nxt = REDIRECT;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                    w_valid_nxt = 1'b0;
                end
            end
            REDIRECT: begin
                if (w_handshake) begin
                    if (r_pend_vld || w_mispred) begin
                        w_state_nxt    = REDIRECT;
                        w_pc_nxt       = w_slot_pc;
                        w_cause_nxt    = CAUSE_MISPRED;
                        w_flush_if_nxt = 1'b1;
                        w_flush_id_nxt = 1'b1;
                        w_stall_nxt    = 1'b1;
                        w_valid_nxt    = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = IDLE;
                        w_pc_nxt       = '0;
                        w_cause_nxt    = CAUSE_NONE;
                        w_flush_if_nxt = 1'b0;
                        w_flush_id_nxt = 1'b0;
                        w_stall_nxt    = 1'b0;
                        w_valid_nxt    = 1'b0;
                    end
                end else if (w_mispred) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_pc_nxt  = ex_pcn;
                end else begin
                    w_pend_vld_nxt = r_pend_vld;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_pc_nxt       = '0;
                w_cause_nxt    = CAUSE_NONE;
                w_pend_vld_nxt = 1'b0;
                w_pend_pc_nxt  = '0;
                w_flush_if_nxt = 1'b0;
                w_flush_id_nxt = 1'b0;
                w_stall_nxt    = 1'b0;
                w_valid_nxt    = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cause    <= CAUSE_NONE;
            r_pc       <= '0;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
            r_stall    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cause    <= w_cause_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_flush_if <= w_flush_if_nxt;
            r_flush_id <= w_flush_id_nxt;
            r_stall    <= w_stall_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign redirect_valid = r_valid;
    assign redirect_pc    = r_pc;
    assign redirect_cause = r_cause;
    assign flush_if       = r_flush_if;
    assign flush_id       = r_flush_id;
    assign stall_front    = r_stall;

`ifdef REDIRECT_CTRL_PERF_EN
    logic w_inc_mispred, w_inc_trap;
    assign w_inc_mispred = w_handshake & (r_cause == CAUSE_MISPRED);
    assign w_inc_trap    = w_handshake & ((r_cause == CAUSE_DEC) || (r_cause == CAUSE_FETCH));

    sat_counter #(.WIDTH(32)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_mispred),
        .count (mispred_cnt)
    );

    sat_counter #(.WIDTH(32)) u_trap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_trap),
        .count (trap_cnt)
    );
`else
    assign mispred_cnt = 32'd0;
    assign trap_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: stimulus pushes expected redirects,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_redirect_ctrl;

`ifdef REDIRECT_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst_n, enable, ex_valid, if_busy, redirect_ready;
    logic [63:0] ex_pcp, ex_pcn, trap_vec, redirect_pc;
    logic [7:0]  exception;
    logic        redirect_valid, flush_if, flush_id, stall_front;
    logic [1:0]  redirect_cause;
    logic [31:0] mispred_cnt, trap_cnt;

    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  cause;
        logic        fid;
    } exp_t;

    exp_t sb_q[$];
    int   n_err    = 0;
    int   n_checks = 0;
    int   exp_mis  = 0;
    int   exp_trap = 0;

    redirect_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ex_valid       (ex_valid),
        .ex_pcp         (ex_pcp),
        .ex_pcn         (ex_pcn),
        .exception      (exception),
        .trap_vec       (trap_vec),
        .if_busy        (if_busy),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_cause (redirect_cause),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .stall_front    (stall_front),
        .mispred_cnt    (mispred_cnt),
        .trap_cnt       (trap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [1:0] cause, input logic fid);
        exp_t e;
        e.pc = pc; e.cause = cause; e.fid = fid;
        sb_q.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {63'd0, redirect_valid}, 64'd0);
        chk({name, "_fif"},   {63'd0, flush_if},       64'd0);
        chk({name, "_fid"},   {63'd0, flush_id},       64'd0);
        chk({name, "_stall"}, {63'd0, stall_front},    64'd0);
    endtask

    task automatic chk_cnts(input string name);
        chk({name, "_mis_cnt"},  {32'd0, mispred_cnt}, PERF ? 64'(exp_mis)  : 64'd0);
        chk({name, "_trap_cnt"}, {32'd0, trap_cnt},    PERF ? 64'(exp_trap) : 64'd0);
    endtask

    task automatic mispred(input logic [63:0] pcp, input logic [63:0] pcn);
        ex_valid = 1'b1; ex_pcp = pcp; ex_pcn = pcn;
    endtask

    // Monitor: every accepted redirect is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && redirect_valid && redirect_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_redirect", redirect_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc",    redirect_pc,              e.pc);
                chk("sb_cause", {62'd0, redirect_cause},  {62'd0, e.cause});
                chk("sb_fif",   {63'd0, flush_if},        64'd1);
                chk("sb_fid",   {63'd0, flush_id},        {63'd0, e.fid});
                chk("sb_stall", {63'd0, stall_front},     64'd1);
                if (e.cause == 2'd1) exp_mis++;
                else exp_trap++;
            end
        end
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; ex_valid = 1'b0; ex_pcp = 64'd0; ex_pcn = 64'd0;
        exception = 8'd0; trap_vec = 64'd0; if_busy = 1'b0; redirect_ready = 1'b0;
        step(); step();
        chk_idle("reset");
        chk("reset_pc", redirect_pc, 64'd0);
        chk("reset_cause", {62'd0, redirect_cause}, 64'd0);
        chk_cnts("reset");
        rst_n = 1'b1;
        step();

        // 1: plain mispredict, fetch idle, immediate accept
        redirect_ready = 1'b1;
        mispred(64'h1000, 64'h2000);
        push(64'h2000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("t1_valid", {63'd0, redirect_valid}, 64'd1);
        chk("t1_pc", redirect_pc, 64'h2000);
        chk("t1_cause", {62'd0, redirect_cause}, 64'd1);
        chk("t1_fif", {63'd0, flush_if}, 64'd1);
        chk("t1_fid", {63'd0, flush_id}, 64'd1);
        step();
        chk_idle("t1_done");
        chk_cnts("t1_done");

        // 2: decode fault while fetch is busy for three cycles
        exception = 8'h02; trap_vec = 64'h8000_0000; if_busy = 1'b1;
        push(64'h8000_0000, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            exception = 8'h00;
            chk("t2_drain_valid", {63'd0, redirect_valid}, 64'd0);
            chk("t2_drain_fid", {63'd0, flush_id}, 64'd1);
            chk("t2_drain_stall", {63'd0, stall_front}, 64'd1);
        end
        if_busy = 1'b0;
        step();
        chk("t2_valid", {63'd0, redirect_valid}, 64'd1);
        chk("t2_pc", redirect_pc, 64'h8000_0000);
        chk("t2_cause", {62'd0, redirect_cause}, 64'd2);
        step();
        chk_idle("t2_done");
        chk_cnts("t2_done");

        // 3: mispredict and fetch fault together; mispredict wins
        mispred(64'h2F00, 64'h3000);
        exception = 8'h01; trap_vec = 64'h9000;
        push(64'h3000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0; exception = 8'h00;
        chk("t3_pc", redirect_pc, 64'h3000);
        chk("t3_cause", {62'd0, redirect_cause}, 64'd1);
        chk("t3_fid", {63'd0, flush_id}, 64'd1);
        step();
        chk_cnts("t3_done");

        // 4: mispredict parked in the pending slot while fetch stalls
        redirect_ready = 1'b0;
        mispred(64'h1000, 64'h5000);
        push(64'h5000, 2'd1, 1'b1);
        step();
        mispred(64'h1000, 64'h4000);
        push(64'h4000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("t4_hold_pc1", redirect_pc, 64'h5000);
        step();
        chk("t4_hold_pc2", redirect_pc, 64'h5000);
        chk("t4_hold_valid", {63'd0, redirect_valid}, 64'd1);
        redirect_ready = 1'b1;
        step();
        chk("t4_reoffer_valid", {63'd0, redirect_valid}, 64'd1);
        chk("t4_reoffer_pc", redirect_pc, 64'h4000);
        step();
        chk_idle("t4_done");
        chk_cnts("t4_done");

        // 5: asynchronous reset in the middle of a fetch-fault drain
        exception = 8'h01; trap_vec = 64'hA000; if_busy = 1'b1;
        step();
        exception = 8'h00;
        chk("t5_drain_fif", {63'd0, flush_if}, 64'd1);
        chk("t5_drain_fid", {63'd0, flush_id}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        exp_mis = 0; exp_trap = 0;
        chk_idle("t5_async");
        chk("t5_async_pc", redirect_pc, 64'd0);
        chk_cnts("t5_async");
        if_busy = 1'b0;
        step();
        rst_n = 1'b1;
        mispred(64'h100, 64'h6000);
        push(64'h6000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("t5_post_valid", {63'd0, redirect_valid}, 64'd1);
        chk("t5_post_pc", redirect_pc, 64'h6000);
        step();
        chk_cnts("t5_done");

        // 6: enable low blocks new captures
        enable = 1'b0;
        mispred(64'h1000, 64'h7777);
        exception = 8'h03;
        step(); step();
        chk_idle("t6_disabled");
        chk_cnts("t6_disabled");
        ex_valid = 1'b0; exception = 8'h00;
        enable = 1'b1;

        // 7: enable dropped mid-sequence; the sequence still completes
        mispred(64'h1000, 64'h7000);
        if_busy = 1'b1;
        push(64'h7000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0; enable = 1'b0; if_busy = 1'b0;
        step();
        chk("t7_valid", {63'd0, redirect_valid}, 64'd1);
        chk("t7_pc", redirect_pc, 64'h7000);
        step();
        chk_idle("t7_done");
        chk_cnts("t7_done");
        enable = 1'b1;

        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end redirect sequencer for the five-stage RV64I pipeline. Collects flush sources each cycle: EX-stage branch/jump resolution (predicted vs. actual next PC) and IF/ID exception flags. Picks the oldest source and holds IF/ID flushed while any in-flight fetch drains. Then hands the fetch unit a single redirect PC over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, default from `pipeline_pkg` (64): PC width
- `FETCH_ERR_BIT`, default 0: exception-vector bit for a fetch fault
- `DECODE_ERR_BIT`, default 1: exception-vector bit for a decode fault

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  global enable; while low, no new request is accepted
- `ex_valid`  in  1  EX holds a resolved control-flow instruction this cycle
- `ex_pcp`  in  DATA_WIDTH  next PC predicted at fetch
- `ex_pcn`  in  DATA_WIDTH  actual next PC
- `exception`  in  8  per-cause exception flags from IF/ID
- `trap_vec`  in  DATA_WIDTH  trap target (mtvec)
- `if_busy`  in  1  fetch has an outstanding memory request
- `redirect_ready`  in  1  fetch accepts redirect
- `redirect_valid`  out  1  redirect offered
- `redirect_pc`  out  DATA_WIDTH  redirect target
- `redirect_cause`  out  2  `CAUSE_NONE`=0, `CAUSE_MISPRED`=1, `CAUSE_DEC`=2, `CAUSE_FETCH`=3
- `flush_if`  out  1  squash IF stage
- `flush_id`  out  1  squash ID stage
- `stall_front`  out  1  freeze PC generation
- `mispred_cnt`  out  32  saturating mispredict count
- `trap_cnt`  out  32  saturating trap count

## Operation
- Request decode (combinational, gated by `enable`):
  - mispredict = `ex_valid & (ex_pcp != ex_pcn)`
  - dec = `exception[DECODE_ERR_BIT]`
  - fetch = `exception[FETCH_ERR_BIT]`
- Priority is oldest first: mispredict > dec > fetch.
- Targets: mispredict → `ex_pcn`; dec and fetch → `trap_vec`.
- Flush scope:
  - mispredict: IF and ID
  - dec: IF and ID
  - fetch: IF only
- FSM states: `IDLE`, `DRAIN`, `REDIRECT`.
  - `IDLE`: a request latches target, cause and flush scope. Next state is `DRAIN` if `if_busy`, else `REDIRECT`.
  - `DRAIN`: flushes and `stall_front` held. A new mispredict replaces target and cause; an exception is ignored because its instruction is already squashed. Moves to `REDIRECT` in the cycle after `if_busy` is sampled low.
  - `REDIRECT`: `redirect_valid` high; `redirect_pc` and `redirect_cause` stable until `redirect_ready`.
    - A mispredict arriving here goes into a one-entry pending slot; a later mispredict overwrites the slot.
    - On the handshake: if the slot is full, stay in `REDIRECT` with the slot contents and clear the slot; otherwise go to `IDLE`.
- `flush_if`, `flush_id` and `stall_front` are asserted from state entry through the handshake cycle, inclusive.
- Simultaneous mispredict and exception in `IDLE`: mispredict wins and takes IF+ID scope; the exception is dropped.
- `enable` low mid-sequence: the sequence completes; only new captures are blocked.
- Reset (any time): state `IDLE`, all outputs 0, pending slot empty, counters 0.

## Timing
- All outputs are registered.
- Request sampled at edge N with `if_busy`=0: `redirect_valid`, flushes and `stall_front` are high in cycle N+1. With `redirect_ready`=1 in N+1, all are low in N+2.
- With `if_busy`=1 at N: `DRAIN` from N+1. If `if_busy` is first low at edge M, `redirect_valid` is high from M+1.
- Minimum request-to-request spacing is 2 cycles: a request is sampled in the same cycle the FSM re-enters `IDLE`.
- Counters increment one cycle after the handshake, by cause, and saturate at 0xFFFF_FFFF.

## Configuration
- `REDIRECT_CTRL_PERF_EN` defined: `mispred_cnt` and `trap_cnt` are live (one `sat_counter` instance each).
- Not defined: the counters are not instantiated, both ports tie to 0, and there is no other behavioural difference.

## Structure
- `pipeline_pkg` additions:
  - `redirect_cause_e` (2-bit)
  - `redirect_state_e`
  - localparams `FETCH_ERR_BIT`, `DECODE_ERR_BIT`
  - `DATA_WIDTH` is reused from the package
- Sub-module `sat_counter`, parameterised by width, with ports `clk`, `rst_n`, `inc`, `count`.

## Test plan
1. `ex_pcp`=0x1000, `ex_pcn`=0x2000, `ex_valid`=1, `if_busy`=0, `redirect_ready`=1
   - N+1: `redirect_pc`=0x2000, cause=1, `flush_if`=`flush_id`=1
   - N+2: `IDLE`, `mispred_cnt`=1
2. `exception`=0x02, `trap_vec`=0x8000_0000, `if_busy`=1 for 3 cycles
   - `DRAIN` for 3 cycles, `flush_id`=1
   - `redirect_valid` is asserted in the cycle after `if_busy` drops; `redirect_pc`=0x8000_0000, cause=2
3. Mispredict (target 0x3000) and `exception`=0x01 in the same cycle
   - cause=1, pc=0x3000, both flushes asserted
   - `trap_cnt` stays 0
4. In `REDIRECT` with `redirect_ready`=0, inject mispredict to 0x4000
   - `redirect_pc` stays unchanged until the handshake
   - the next cycle re-offers 0x4000
5. Drop `rst_n` during `DRAIN`
   - all outputs 0 immediately (asynchronous)
   - a request in the first cycle after release is serviced normally
6. `enable`=0 with a mispredict present
   - no `redirect_valid`, no flushes, counters unchanged
